// File: rtl/aes_iter_core.sv
`default_nettype none
// ---------------------------------------------------------------------------
// aes_iter_core: iterative AES-128/192/256 cipher/inverse cipher, one round
// per clock, valid/ready on both sides.     Revision: 1.0
// ---------------------------------------------------------------------------
module aes_iter_core #(
  parameter int Nk = 4,
  parameter int Nr = Nk + 6
) (
  input  logic                   clks,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   mode,
  input  logic [0:127]           data_in,
  input  logic [0:128*(Nr+1)-1]  keys,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [0:127]           data_out,
  output logic                   busy
);

  if (!((Nk == 4) || (Nk == 6) || (Nk == 8)) || (Nr != Nk + 6)) begin : g_bad_params
    $error("aes_iter_core: Nk must be 4, 6 or 8 and Nr must equal Nk+6");
  end

  localparam logic [4:0] NR5 = 5'(Nr);

  typedef enum logic [1:0] {IDLE = 2'd0, ROUND = 2'd1, FINAL = 2'd2, DONE = 2'd3} state_t;

  state_t       state, state_d;
  logic [4:0]   round, round_d;
  logic [0:127] state_reg, state_reg_d, data_out_d;
  logic         out_valid_d, mode_q, mode_q_d;
  logic         key_mode;
  logic [4:0]   key_idx;
  logic [0:127] rk, sb, rnd;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] p, r;
    p = a;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = ginv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return ginv({a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05);
  endfunction

  // Byte substitution and row shift commute, so both directions share one pass
  function automatic logic [0:127] sub_shift(input logic [0:127] s, input logic inv);
    logic [0:127] o;
    logic [7:0]   b;
    int           src;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        src = inv ? ((c - r + 4) % 4) : ((c + r) % 4);
        b   = s[8*(r+4*src) +: 8];
        o[8*(r+4*c) +: 8] = inv ? inv_sbox(b) : sbox(b);
      end
    end
    return o;
  endfunction

  function automatic logic [0:127] mix(input logic [0:127] s, input logic inv);
    logic [0:127] o;
    logic [31:0]  coef;
    logic [7:0]   acc;
    o    = '0;
    coef = inv ? 32'h0e0b0d09 : 32'h02030101;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        acc = '0;
        for (int j = 0; j < 4; j++)
          acc = acc ^ gmul(coef[8*(3-((j-r+4)%4)) +: 8], s[8*(j+4*c) +: 8]);
        o[8*(r+4*c) +: 8] = acc;
      end
    end
    return o;
  endfunction

  always_ff @(posedge clks or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      round     <= '0;
      state_reg <= '0;
      data_out  <= '0;
      out_valid <= 1'b0;
      mode_q    <= 1'b0;
    end else begin
      state     <= state_d;
      round     <= round_d;
      state_reg <= state_reg_d;
      data_out  <= data_out_d;
      out_valid <= out_valid_d;
      mode_q    <= mode_q_d;
    end
  end

  always_comb begin
    state_d     = state;
    round_d     = round;
    state_reg_d = state_reg;
    data_out_d  = data_out;
    out_valid_d = out_valid;
    mode_q_d    = mode_q;
    in_ready    = (state == IDLE);
    busy        = (state != IDLE);

    // round is 0 in IDLE and Nr in FINAL, so one index rule covers every key
    key_mode = (state == IDLE) ? mode : mode_q;
    key_idx  = key_mode ? (NR5 - round) : round;
    rk       = keys[128*key_idx +: 128];

    sb = sub_shift(state_reg, mode_q);
    if (!mode_q) rnd = (state == FINAL) ? (sb ^ rk) : (mix(sb, 1'b0) ^ rk);
    else         rnd = (state == FINAL) ? (sb ^ rk) : mix(sb ^ rk, 1'b1);

    case (state)
      IDLE: begin
        if (in_valid) begin
          mode_q_d    = mode;
          state_reg_d = data_in ^ rk;
          round_d     = 5'd1;
          state_d     = ROUND;
        end
      end
      ROUND: begin
        state_reg_d = rnd;
        round_d     = round + 5'd1;
        if (round == NR5 - 5'd1) state_d = FINAL;
      end
      FINAL: begin
        state_reg_d = rnd;
        data_out_d  = rnd;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          round_d     = '0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_aes_iter_core.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_aes_iter_core: randomized self-checking bench for Nk=4/6/8 builds against
// a table-driven AES reference.     Revision: 1.0
// ---------------------------------------------------------------------------
module tb_aes_iter_core;

  logic clks, reset;
  logic in_valid [3];
  logic in_ready [3];
  logic out_valid [3];
  logic busy [3];
  logic [0:127] data_out [3];
  logic mode, out_ready;
  logic [0:127] data_in;
  logic [0:128*11-1] keys4;
  logic [0:128*13-1] keys6;
  logic [0:128*15-1] keys8;

  int vectors, miscompares;
  logic [7:0] sbox_t [256];
  logic [7:0] isbox_t [256];
  logic [7:0] sched [240];

  localparam logic [0:127] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [0:255] K16 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [0:255] K24 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [0:255] K32 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  aes_iter_core #(.Nk(4)) u4 (.clks(clks), .reset(reset), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .mode(mode), .data_in(data_in), .keys(keys4), .out_valid(out_valid[0]), .out_ready(out_ready),
    .data_out(data_out[0]), .busy(busy[0]));
  aes_iter_core #(.Nk(6)) u6 (.clks(clks), .reset(reset), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .mode(mode), .data_in(data_in), .keys(keys6), .out_valid(out_valid[1]), .out_ready(out_ready),
    .data_out(data_out[1]), .busy(busy[1]));
  aes_iter_core #(.Nk(8)) u8 (.clks(clks), .reset(reset), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .mode(mode), .data_in(data_in), .keys(keys8), .out_valid(out_valid[2]), .out_ready(out_ready),
    .data_out(data_out[2]), .busy(busy[2]));

  initial begin
    clks = 1'b0;
    forever #5 clks = ~clks;
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = xt(a);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  // Walk the multiplicative group with generator 3 and its inverse in step
  task automatic build_tables();
    logic [7:0] p = 8'h01, q = 8'h01, x;
    do begin
      p = p ^ xt(p);
      q ^= q << 1; q ^= q << 2; q ^= q << 4;
      if (q[7]) q ^= 8'h09;
      x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
      sbox_t[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_t[0] = 8'h63;
    for (int i = 0; i < 256; i++) isbox_t[sbox_t[i]] = 8'(i);
  endtask

  task automatic expand_key(input logic [0:255] key, input int nk);
    logic [7:0] t [4];
    logic [7:0] tmp, rcon;
    rcon = 8'h01;
    for (int i = 0; i < 4*nk; i++) sched[i] = key[8*i +: 8];
    for (int i = nk; i < 4*(nk+7); i++) begin
      for (int j = 0; j < 4; j++) t[j] = sched[4*(i-1)+j];
      if (i % nk == 0) begin
        tmp = t[0]; t[0] = t[1]; t[1] = t[2]; t[2] = t[3]; t[3] = tmp;
        for (int j = 0; j < 4; j++) t[j] = sbox_t[t[j]];
        t[0] ^= rcon;
        rcon = xt(rcon);
      end else if (nk > 6 && i % nk == 4) begin
        for (int j = 0; j < 4; j++) t[j] = sbox_t[t[j]];
      end
      for (int j = 0; j < 4; j++) sched[4*i+j] = sched[4*(i-nk)+j] ^ t[j];
    end
  endtask

  function automatic logic [0:127] rkey(input int r);
    logic [0:127] k;
    for (int i = 0; i < 16; i++) k[8*i +: 8] = sched[16*r+i];
    return k;
  endfunction

  function automatic logic [0:127] sub_bytes(input logic [0:127] s, input bit inv);
    for (int i = 0; i < 16; i++) s[8*i +: 8] = inv ? isbox_t[s[8*i +: 8]] : sbox_t[s[8*i +: 8]];
    return s;
  endfunction

  function automatic logic [0:127] shift_rows(input logic [0:127] s, input bit inv);
    logic [0:127] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[8*(r+4*c) +: 8] = inv ? s[8*(r+4*((c+4-r)%4)) +: 8] : s[8*(r+4*((c+r)%4)) +: 8];
    return o;
  endfunction

  function automatic logic [0:127] mix_cols(input logic [0:127] s, input bit inv);
    logic [0:127] o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[32*c +: 8]; a1 = s[32*c+8 +: 8]; a2 = s[32*c+16 +: 8]; a3 = s[32*c+24 +: 8];
      if (!inv)
        o[32*c +: 32] = {mul(a0,2)^mul(a1,3)^a2^a3, a0^mul(a1,2)^mul(a2,3)^a3,
                         a0^a1^mul(a2,2)^mul(a3,3), mul(a0,3)^a1^a2^mul(a3,2)};
      else
        o[32*c +: 32] = {mul(a0,14)^mul(a1,11)^mul(a2,13)^mul(a3,9), mul(a0,9)^mul(a1,14)^mul(a2,11)^mul(a3,13),
                         mul(a0,13)^mul(a1,9)^mul(a2,14)^mul(a3,11), mul(a0,11)^mul(a1,13)^mul(a2,9)^mul(a3,14)};
    end
    return o;
  endfunction

  function automatic logic [0:127] ref_aes(input logic [0:127] blk, input bit dec, input int nr);
    logic [0:127] s;
    if (!dec) begin
      s = blk ^ rkey(0);
      for (int r = 1; r <= nr; r++) begin
        s = shift_rows(sub_bytes(s, 0), 0);
        if (r < nr) s = mix_cols(s, 0);
        s ^= rkey(r);
      end
    end else begin
      s = blk ^ rkey(nr);
      for (int r = nr - 1; r >= 0; r--) begin
        s = sub_bytes(shift_rows(s, 1), 1) ^ rkey(r);
        if (r > 0) s = mix_cols(s, 1);
      end
    end
    return s;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clks);
    #1;
  endtask

  function automatic int nr_of(input int sel);
    return 10 + 2*sel;
  endfunction

  task automatic load_keys(input int sel, input logic [0:255] key);
    expand_key(key, 4 + 2*sel);
    for (int i = 0; i < 16*(nr_of(sel)+1); i++) begin
      case (sel)
        0: keys4[8*i +: 8] = sched[i];
        1: keys6[8*i +: 8] = sched[i];
        default: keys8[8*i +: 8] = sched[i];
      endcase
    end
  endtask

  task automatic run_block(input int sel, input logic [0:127] blk, input bit m, input logic [0:127] exp,
                           input int hold, input bit toggle, input string tag);
    int lat;
    logic [0:127] held;
    data_in = blk; mode = m; out_ready = 1'b0; in_valid[sel] = 1'b1;
    vectors++;
    if (in_ready[sel] !== 1'b1) begin
      miscompares++; $display("FAIL %s in_ready_idle: got %b want 1", tag, in_ready[sel]);
    end
    tick();
    in_valid[sel] = 1'b0;
    data_in = {$urandom(), $urandom(), $urandom(), $urandom()};
    lat = 0;
    while (out_valid[sel] !== 1'b1 && lat < 40) begin
      if (toggle) mode = ~mode;
      tick();
      lat++;
    end
    vectors++;
    if (lat != nr_of(sel)) begin
      miscompares++; $display("FAIL %s latency: got %0d want %0d", tag, lat, nr_of(sel));
    end
    vectors++;
    if (data_out[sel] !== exp) begin
      miscompares++; $display("FAIL %s data_out: got %h want %h", tag, data_out[sel], exp);
    end
    held = data_out[sel];
    repeat (hold) begin
      tick();
      vectors++;
      if (out_valid[sel] !== 1'b1 || data_out[sel] !== held || in_ready[sel] !== 1'b0) begin
        miscompares++;
        $display("FAIL %s hold: got ov=%b rdy=%b d=%h want ov=1 rdy=0 d=%h", tag, out_valid[sel],
                 in_ready[sel], data_out[sel], held);
      end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    vectors++;
    if (out_valid[sel] !== 1'b0 || in_ready[sel] !== 1'b1 || busy[sel] !== 1'b0) begin
      miscompares++;
      $display("FAIL %s release: got ov=%b rdy=%b busy=%b want 0 1 0", tag, out_valid[sel], in_ready[sel], busy[sel]);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #7;
    for (int s = 0; s < 3; s++) begin
      vectors++;
      if (out_valid[s] !== 1'b0 || busy[s] !== 1'b0 || data_out[s] !== 128'h0) begin
        miscompares++;
        $display("FAIL reset_state[%0d]: got ov=%b busy=%b d=%h want 0 0 0", s, out_valid[s], busy[s], data_out[s]);
      end
    end
    #5 reset = 1'b1;
    tick();
    for (int s = 0; s < 3; s++) begin
      vectors++;
      if (in_ready[s] !== 1'b1) begin
        miscompares++; $display("FAIL reset_ready[%0d]: got %b want 1", s, in_ready[s]);
      end
    end
  endtask

  task automatic test_fips();
    load_keys(0, K16);
    run_block(0, PT, 1'b0, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 0, 1'b0, "fips128_enc");
    run_block(0, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1'b1, PT, 0, 1'b0, "fips128_dec");
    load_keys(1, K24);
    run_block(1, PT, 1'b0, 128'hdda97ca4864cdfe06eaf70a0ec0d7191, 0, 1'b0, "fips192_enc");
    run_block(1, 128'hdda97ca4864cdfe06eaf70a0ec0d7191, 1'b1, PT, 0, 1'b0, "fips192_dec");
    load_keys(2, K32);
    run_block(2, PT, 1'b0, 128'h8ea2b7ca516745bfeafc49904b496089, 0, 1'b0, "fips256_enc");
    run_block(2, 128'h8ea2b7ca516745bfeafc49904b496089, 1'b1, PT, 0, 1'b0, "fips256_dec");
  endtask

  task automatic test_random();
    logic [0:255] k;
    logic [0:127] blk;
    bit m;
    for (int n = 0; n < 18; n++) begin
      int sel;
      sel = (n < 12) ? 0 : (n < 15) ? 1 : 2;
      k   = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      blk = {$urandom(), $urandom(), $urandom(), $urandom()};
      m   = 1'($urandom_range(0, 1));
      load_keys(sel, k);
      run_block(sel, blk, m, ref_aes(blk, m, nr_of(sel)), $urandom_range(0, 3), 1'($urandom_range(0, 1)), "random");
    end
  endtask

  task automatic test_backpressure();
    logic [0:127] b, held, exp_b;
    bit mb;
    int lat;
    load_keys(0, K16);
    b  = {$urandom(), $urandom(), $urandom(), $urandom()};
    mb = 1'($urandom_range(0, 1));
    exp_b = ref_aes(b, mb, 10);
    data_in = PT; mode = 1'b0; out_ready = 1'b0; in_valid[0] = 1'b1;
    tick();
    data_in = b; mode = mb;
    lat = 0;
    while (out_valid[0] !== 1'b1 && lat < 40) begin tick(); lat++; end
    vectors++;
    if (lat != 10 || data_out[0] !== 128'h69c4e0d86a7b0430d8cdb78070b4c55a) begin
      miscompares++; $display("FAIL bp_first: got lat=%0d d=%h want 10 69c4e0d86a7b0430d8cdb78070b4c55a", lat, data_out[0]);
    end
    held = data_out[0];
    repeat (5) begin
      tick();
      vectors++;
      if (out_valid[0] !== 1'b1 || data_out[0] !== held || in_ready[0] !== 1'b0 || busy[0] !== 1'b1) begin
        miscompares++;
        $display("FAIL bp_stall: got ov=%b rdy=%b busy=%b d=%h want 1 0 1 %h", out_valid[0], in_ready[0],
                 busy[0], data_out[0], held);
      end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    vectors++;
    if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1 || busy[0] !== 1'b0 || data_out[0] !== held) begin
      miscompares++;
      $display("FAIL bp_done_only: got ov=%b rdy=%b busy=%b d=%h want 0 1 0 %h", out_valid[0], in_ready[0],
               busy[0], data_out[0], held);
    end
    tick();
    in_valid[0] = 1'b0;
    vectors++;
    if (busy[0] !== 1'b1 || in_ready[0] !== 1'b0) begin
      miscompares++; $display("FAIL bp_second_accept: got busy=%b rdy=%b want 1 0", busy[0], in_ready[0]);
    end
    lat = 0;
    while (out_valid[0] !== 1'b1 && lat < 40) begin mode = ~mode; tick(); lat++; end
    vectors++;
    if (lat != 10 || data_out[0] !== exp_b) begin
      miscompares++; $display("FAIL bp_second: got lat=%0d d=%h want 10 %h", lat, data_out[0], exp_b);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    load_keys(0, K16);
    data_in = PT; mode = 1'b0; in_valid[0] = 1'b1;
    tick();
    in_valid[0] = 1'b0;
    repeat (4) tick();
    #2 reset = 1'b0;
    #1;
    vectors++;
    if (out_valid[0] !== 1'b0 || busy[0] !== 1'b0 || data_out[0] !== 128'h0 || in_ready[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_mid: got ov=%b busy=%b rdy=%b d=%h want 0 0 1 0", out_valid[0], busy[0],
               in_ready[0], data_out[0]);
    end
    @(posedge clks);
    #3 reset = 1'b1;
    tick();
    run_block(0, PT, 1'b0, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 0, 1'b0, "after_reset");
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    reset = 1'b0; mode = 1'b0; out_ready = 1'b0; data_in = '0;
    keys4 = '0; keys6 = '0; keys8 = '0;
    for (int s = 0; s < 3; s++) in_valid[s] = 1'b0;
    build_tables();
    test_reset();
    test_fips();
    test_random();
    test_backpressure();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
